// File: rtl/uart_word_bridge.sv
// Byte-to-word bridge between the UART byte interface and a word-wide valid/ready datapath.
// RX packs bytes first-byte-MSB into words; TX serialises words MSB-byte-first.
module uart_word_bridge #(
  parameter int unsigned NBYTES     = 4,
  parameter int unsigned GAP_CYCLES = 50000,
  localparam int unsigned W         = 8 * NBYTES
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [7:0]   RX_DATA,
  input  logic         RX_DONE,
  output logic [7:0]   TX_DATA,
  output logic         TX_START,
  input  logic         TX_DONE,
  output logic [W-1:0] RX_WORD,
  output logic         RX_WORD_VALID,
  input  logic         RX_WORD_READY,
  output logic         RX_OVERRUN,
  output logic         RX_FRAME_ERR,
  input  logic [W-1:0] TX_WORD,
  input  logic         TX_WORD_VALID,
  output logic         TX_WORD_READY
);

  localparam int unsigned CW = $clog2(NBYTES);
  localparam int unsigned GW = $clog2(GAP_CYCLES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_START = 2'd1;
  localparam logic [1:0] T_WAIT  = 2'd2;

  // Strobe edge detection
  logic rx_done_q, tx_done_q;
  logic rx_ev, tx_ev;

  assign rx_ev = RX_DONE & ~rx_done_q;
  assign tx_ev = TX_DONE & ~tx_done_q;

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [W-9:0]  sh_q, sh_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [W-1:0]  word_q, word_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic [W-1:0]  rx_shift;

  assign rx_shift = {sh_q, RX_DATA};

  always_comb begin
    rx_cnt_d    = rx_cnt_q;
    sh_d        = sh_q;
    gap_d       = gap_q;
    word_d      = word_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    if (valid_q && RX_WORD_READY) begin
      valid_d = 1'b0;
    end

    if (rx_ev) begin
      // A byte arriving on the timeout cycle takes priority over the discard.
      gap_d = '0;
      sh_d  = rx_shift[W-9:0];
      if (rx_cnt_q == LAST_BYTE) begin
        rx_cnt_d = '0;
        if (!valid_q || RX_WORD_READY) begin
          word_d  = rx_shift;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + CW'(1);
      end
    end else if (rx_cnt_q == '0) begin
      gap_d = '0;
    end else if (gap_q == GAP_LAST) begin
      rx_cnt_d    = '0;
      gap_d       = '0;
      frame_err_d = 1'b1;
    end else begin
      gap_d = gap_q + GW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_done_q   <= 1'b0;
      rx_cnt_q    <= '0;
      sh_q        <= '0;
      gap_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_done_q   <= RX_DONE;
      rx_cnt_q    <= rx_cnt_d;
      sh_q        <= sh_d;
      gap_q       <= gap_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign RX_WORD       = word_q;
  assign RX_WORD_VALID = valid_q;
  assign RX_OVERRUN    = overrun_q;
  assign RX_FRAME_ERR  = frame_err_q;

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  tx_sh_q, tx_sh_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [7:0]    tx_data_q, tx_data_d;

  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;

    case (state_q)
      T_IDLE: begin
        if (TX_WORD_VALID) begin
          tx_sh_d   = TX_WORD;
          tx_data_d = TX_WORD[W-1 -: 8];
          idx_d     = '0;
          state_d   = T_START;
        end
      end
      T_START: begin
        state_d = T_WAIT;
      end
      T_WAIT: begin
        if (tx_ev) begin
          if (idx_q == LAST_BYTE) begin
            state_d = T_IDLE;
          end else begin
            // Next byte is loaded into TX_DATA now so it is valid alongside TX_START.
            tx_sh_d   = tx_sh_q << 8;
            tx_data_d = tx_sh_q[W-9 -: 8];
            idx_d     = idx_q + CW'(1);
            state_d   = T_START;
          end
        end
      end
      default: begin
        state_d = T_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_done_q <= 1'b0;
      state_q   <= T_IDLE;
      tx_sh_q   <= '0;
      idx_q     <= '0;
      tx_data_q <= '0;
    end else begin
      tx_done_q <= TX_DONE;
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign TX_DATA       = tx_data_q;
  assign TX_START      = (state_q == T_START);
  assign TX_WORD_READY = (state_q == T_IDLE);

endmodule

// File: doc/uart_word_bridge.md
Name: uart_word_bridge

Overview:
- Byte-to-word client for the UART block, sitting between the UART byte interface and the CORDIC exponential datapath.
- Receive path: collects bytes (RX_DATA/RX_DONE) into NBYTES-byte words and presents them with valid/ready.
- Transmit path: accepts result words with valid/ready and serialises them MSB-byte-first through TX_START/TX_DATA/TX_DONE.
- An inter-byte gap timer discards partial received words so the host can resynchronise.

Parameters:
NBYTES, 4, bytes per word; word width W = 8*NBYTES; legal range 2..8
GAP_CYCLES, 50000, idle CLK cycles after which a partial RX word is discarded; must be >= 2

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-low
RX_DATA  in  8  received byte from UART
RX_DONE  in  1  UART byte-received strobe
TX_DATA  out  8  byte to UART transmitter
TX_START  out  1  one-cycle transmit request to UART
TX_DONE  in  1  UART byte-transmitted strobe
RX_WORD  out  W  assembled word, first received byte in bits [W-1:W-8]
RX_WORD_VALID  out  1  RX_WORD holds an unconsumed word
RX_WORD_READY  in  1  consumer accepts RX_WORD
RX_OVERRUN  out  1  one-cycle pulse: completed word dropped
RX_FRAME_ERR  out  1  one-cycle pulse: partial word discarded by gap timeout
TX_WORD  in  W  word to send, bits [W-1:W-8] sent first
TX_WORD_VALID  in  1  TX_WORD is valid
TX_WORD_READY  out  1  bridge can accept a word (high only in T_IDLE)

Behaviour:
- Reset (RST=0, asynchronous): all registers cleared; TX FSM to T_IDLE.
  - Output reset values: RX_WORD=0, RX_WORD_VALID=0, RX_OVERRUN=0, RX_FRAME_ERR=0, TX_START=0, TX_DATA=0, TX_WORD_READY=1.
  - Reset mid-word or mid-transmission abandons all progress; no partial output.
- Strobe detection: RX_DONE and TX_DONE are edge-detected with one register each. An event is a cycle where the signal is 1 and was 0 in the previous cycle. A level held high counts once.
- RX assembly:
  - Byte counter rx_cnt runs 0..NBYTES-1.
  - Shift register takes each byte: sh <= {sh[W-9:0], RX_DATA}.
  - On the event completing byte NBYTES-1: rx_cnt wraps to 0.
    - If the holding register is free, or is being consumed this same cycle (valid&ready), RX_WORD <= {sh[W-9:0], RX_DATA} and RX_WORD_VALID=1 on the next cycle.
    - Latency: last RX_DONE edge to RX_WORD_VALID is 1 cycle after the detect cycle.
  - Otherwise the new word is dropped, RX_WORD is unchanged, and RX_OVERRUN pulses 1 cycle.
- RX handshake: RX_WORD_VALID clears on the cycle after valid&ready unless a new word loads in that same cycle, in which case it stays 1 with the new data. RX_WORD is stable while valid and not consumed.
- Gap timer:
  - Cleared on every RX byte event and while rx_cnt==0; increments otherwise.
  - When it reaches GAP_CYCLES-1 with rx_cnt!=0: rx_cnt<=0, timer<=0, RX_FRAME_ERR pulses 1 cycle.
  - A byte event in the same cycle as timeout wins: byte accepted, no error.
  - A held RX_WORD is unaffected by the timeout.
- TX FSM (3 states):
  - T_IDLE: TX_WORD_READY=1. On TX_WORD_VALID, capture TX_WORD into tx_sh, idx<=0, go to T_START.
  - T_START: TX_START=1 for exactly this cycle, TX_DATA=tx_sh[W-1:W-8] (registered, valid in the same cycle as TX_START). Go to T_WAIT.
  - T_WAIT: TX_DATA held stable. On a TX_DONE event:
    - If idx==NBYTES-1, go to T_IDLE.
    - Else tx_sh<<=8, idx++, go to T_START.
  - A TX_DONE event outside T_WAIT is ignored.
- Timing and throughput:
  - Word accept to first TX_START: 1 cycle.
  - TX_DONE event to next TX_START: 1 cycle.
  - Back-to-back words: TX_WORD_READY returns the cycle after the final TX_DONE event.
- RX and TX paths are fully independent; simultaneous activity has no interaction.

Test Plan:
1. Reset release, then RX bytes 0x3F,0x80,0x00,0x01 (RX_DONE pulses ≥20 cycles apart) with RX_WORD_READY=1 -> RX_WORD=0x3F800001, RX_WORD_VALID high exactly 1 cycle, no error pulses.
2. RX_WORD_READY=0; send two full words 0x11223344 then 0xAABBCCDD -> RX_WORD stays 0x11223344 valid, RX_OVERRUN pulses once at the 8th byte. Raise ready -> valid drops next cycle.
3. Send 2 bytes 0xDE,0xAD, idle GAP_CYCLES (override 100) -> RX_FRAME_ERR pulses once at cycle 99 of idle. Then 0x01,0x02,0x03,0x04 -> RX_WORD=0x01020304.
4. TX_WORD=0x40490FDB, VALID 1 cycle, UART model returns TX_DONE 10 cycles after each TX_START -> four TX_START pulses with TX_DATA 0x40,0x49,0x0F,0xDB. TX_WORD_READY low throughout, high 1 cycle after the 4th TX_DONE.
5. Hold TX_DONE high for 5 cycles after the first byte -> only one byte advance. Spurious TX_DONE in T_IDLE -> no TX_START.
6. Assert RST=0 during the 2nd TX byte and the 3rd RX byte -> all outputs immediately at reset values. After release, a fresh word on each path completes correctly with no residue.
